// File: rtl/bsg_nonsynth_dram_trace_player.sv
// Replays a per-channel trace ROM as DRAM requests and checks read returns
// against the data field recorded when each read was issued.
module bsg_nonsynth_dram_trace_player #(
  parameter int num_channels_p       = 8,
  parameter int channel_addr_width_p = 29,
  parameter int data_width_p         = 256,
  parameter int rom_addr_width_p     = 20,
  parameter int max_outstanding_p    = 8
) (
  input  logic                                                              clk_i,
  input  logic                                                              reset_i,
  output logic [num_channels_p-1:0][rom_addr_width_p-1:0]                   rom_addr_o,
  input  logic [num_channels_p-1:0][4+1+channel_addr_width_p+data_width_p-1:0] rom_data_i,
  output logic [num_channels_p-1:0]                                         v_o,
  output logic [num_channels_p-1:0]                                         write_not_read_o,
  output logic [num_channels_p-1:0][channel_addr_width_p-1:0]               ch_addr_o,
  input  logic [num_channels_p-1:0]                                         yumi_i,
  output logic [num_channels_p-1:0]                                         data_v_o,
  output logic [num_channels_p-1:0][data_width_p-1:0]                       data_o,
  input  logic [num_channels_p-1:0]                                         data_yumi_i,
  input  logic [num_channels_p-1:0]                                         data_v_i,
  input  logic [num_channels_p-1:0][data_width_p-1:0]                       data_i,
  output logic [num_channels_p-1:0]                                         done_o,
  output logic [num_channels_p-1:0]                                         error_o,
  output logic                                                              all_done_o
);

  localparam int ew    = 4 + 1 + channel_addr_width_p + data_width_p;
  localparam int ptr_w = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_w = $clog2(max_outstanding_p + 1);

  localparam logic [3:0] op_send   = 4'd0;
  localparam logic [3:0] op_drain  = 4'd1;
  localparam logic [3:0] op_finish = 4'd2;

  typedef enum logic [1:0] {
    S_SEND  = 2'd0,
    S_WDATA = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    if (p == ptr_w'(max_outstanding_p - 1)) return '0;
    else return p + ptr_w'(1);
  endfunction

  for (genvar c = 0; c < num_channels_p; c++) begin : ch
    state_e                          state_r;
    logic [rom_addr_width_p-1:0]     pc_r;
    logic                            finish_r;
    logic                            error_r;
    logic [data_width_p-1:0]         wdata_r;
    logic [data_width_p-1:0]         fifo_mem [max_outstanding_p];
    logic [ptr_w-1:0]                rd_ptr_r;
    logic [ptr_w-1:0]                wr_ptr_r;
    logic [cnt_w-1:0]                count_r;

    logic [3:0]                      e_op;
    logic                            e_wnr;
    logic [channel_addr_width_p-1:0] e_addr;
    logic [data_width_p-1:0]         e_data;

    logic full, is_send_op, req_v, req_take, push, pop, underflow, mismatch, drained;

    assign {e_op, e_wnr, e_addr, e_data} = rom_data_i[c];

    assign full       = (count_r == cnt_w'(max_outstanding_p));
    assign is_send_op = (state_r == S_SEND) && (e_op == op_send);
    // Writes never occupy a FIFO slot, so only reads are throttled.
    assign req_v      = is_send_op && (e_wnr || !full);
    assign req_take   = req_v && yumi_i[c];
    assign push       = req_take && !e_wnr;
    assign pop        = data_v_i[c] && (count_r != '0);
    assign underflow  = data_v_i[c] && (count_r == '0);
    assign mismatch   = pop && (data_i[c] != fifo_mem[rd_ptr_r]);
    // Counts the final return of this cycle, so DRAIN can exit alongside it.
    assign drained    = (count_r == '0) || ((count_r == cnt_w'(1)) && data_v_i[c]);

    assign rom_addr_o[c]       = reset_i ? '0 : pc_r;
    assign v_o[c]              = !reset_i && req_v;
    assign write_not_read_o[c] = e_wnr;
    assign ch_addr_o[c]        = e_addr;
    assign data_v_o[c]         = !reset_i && (state_r == S_WDATA);
    assign data_o[c]           = wdata_r;
    assign done_o[c]           = !reset_i && (state_r == S_DONE);
    assign error_o[c]          = !reset_i && error_r;

    // Stage p0: control state, pointers and outstanding count
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        state_r  <= S_SEND;
        pc_r     <= '0;
        finish_r <= 1'b0;
        error_r  <= 1'b0;
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
        count_r  <= '0;
      end else begin
        if (push) wr_ptr_r <= next_ptr(wr_ptr_r);
        if (pop)  rd_ptr_r <= next_ptr(rd_ptr_r);
        if (push && !pop)      count_r <= count_r + cnt_w'(1);
        else if (pop && !push) count_r <= count_r - cnt_w'(1);
        if (underflow || mismatch) error_r <= 1'b1;

        case (state_r)
          S_SEND: begin
            case (e_op)
              op_send: begin
                if (req_take) begin
                  if (e_wnr) state_r <= S_WDATA;
                  else       pc_r    <= pc_r + 1'b1;
                end
              end
              op_drain: begin
                state_r  <= S_DRAIN;
                finish_r <= 1'b0;
              end
              op_finish: begin
                state_r  <= S_DRAIN;
                finish_r <= 1'b1;
              end
              default: begin
                error_r <= 1'b1;
                state_r <= S_DONE;
              end
            endcase
          end
          S_WDATA: begin
            if (data_yumi_i[c]) begin
              pc_r    <= pc_r + 1'b1;
              state_r <= S_SEND;
            end
          end
          S_DRAIN: begin
            if (drained) begin
              pc_r    <= pc_r + 1'b1;
              state_r <= finish_r ? S_DONE : S_SEND;
            end
          end
          default: ;
        endcase
      end
    end

    // Stage p0: data storage, never reset
    always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr_r] <= e_data;
      if (is_send_op && e_wnr && yumi_i[c]) wdata_r <= e_data;
    end
  end

  assign all_done_o = &done_o;

endmodule

// File: tb/tb_bsg_nonsynth_dram_trace_player.sv
// Directed bench for the DRAM trace player: a ROM model plus an echoing
// memory model per channel drive the DUT, one task per scenario.
module tb_bsg_nonsynth_dram_trace_player;
  localparam int NC = 2;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int RW = 4;
  localparam int MO = 2;
  localparam int EW = 4 + 1 + AW + DW;

  logic clk;
  logic reset_i;
  logic [NC-1:0][RW-1:0] rom_addr_o;
  logic [NC-1:0][EW-1:0] rom_data_i;
  logic [NC-1:0] v_o, write_not_read_o, yumi_i, data_v_o, data_yumi_i, data_v_i;
  logic [NC-1:0] done_o, error_o;
  logic [NC-1:0][AW-1:0] ch_addr_o;
  logic [NC-1:0][DW-1:0] data_o, data_i;
  logic all_done_o;

  bsg_nonsynth_dram_trace_player #(
    .num_channels_p(NC), .channel_addr_width_p(AW), .data_width_p(DW),
    .rom_addr_width_p(RW), .max_outstanding_p(MO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .v_o(v_o), .write_not_read_o(write_not_read_o), .ch_addr_o(ch_addr_o), .yumi_i(yumi_i),
    .data_v_o(data_v_o), .data_o(data_o), .data_yumi_i(data_yumi_i),
    .data_v_i(data_v_i), .data_i(data_i), .done_o(done_o), .error_o(error_o),
    .all_done_o(all_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [EW-1:0] rom [NC][16];
  logic [DW-1:0] mem [NC][256];
  always_comb begin
    for (int c = 0; c < NC; c++) rom_data_i[c] = rom[c][rom_addr_o[c]];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_rd [NC];
  int n_wr [NC];
  int both_hi = 0;
  int wr_out_viol = 0;
  logic [AW-1:0] wr_addr [NC];
  logic [AW-1:0] rq_addr [NC][$];
  int            rq_cyc  [NC][$];
  bit rand_mode = 0;
  bit yumi_en = 1;
  int ret_budget = -1;
  logic [NC-1:0] force_dv = '0;
  logic [DW-1:0] force_data = '0;

  localparam logic [3:0] OP_SEND = 4'd0, OP_DRAIN = 4'd1, OP_FINISH = 4'd2;

  function automatic logic [EW-1:0] ent(input logic [3:0] op, input logic wnr,
                                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {op, wnr, a, d};
  endfunction

  task automatic clear_rom();
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < 16; i++) rom[c][i] = ent(OP_FINISH, 1'b0, 8'h00, 8'h00);
  endtask

  // One cycle: observe at the falling edge, then drive the next rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int c = 0; c < NC; c++) begin
      yumi_i[c] = 1'b0; data_yumi_i[c] = 1'b0; data_v_i[c] = 1'b0; data_i[c] = '0;
      if (v_o[c] && data_v_o[c]) both_hi++;
      if (reset_i) begin
        rq_addr[c].delete(); rq_cyc[c].delete();
      end else begin
        if (force_dv[c]) begin
          data_v_i[c] = 1'b1; data_i[c] = force_data;
        end else if (rq_addr[c].size() > 0 && rq_cyc[c][0] < cyc && ret_budget != 0 &&
                     (!rand_mode || $urandom_range(0, 2) != 0)) begin
          data_v_i[c] = 1'b1;
          data_i[c] = mem[c][rq_addr[c][0]];
          void'(rq_addr[c].pop_front());
          void'(rq_cyc[c].pop_front());
          if (ret_budget > 0) ret_budget--;
        end
        yumi_i[c] = yumi_en && (!rand_mode || $urandom_range(0, 1) == 1);
        data_yumi_i[c] = !rand_mode || $urandom_range(0, 1) == 1;
        if (v_o[c] && yumi_i[c]) begin
          if (write_not_read_o[c]) begin
            wr_addr[c] = ch_addr_o[c];
            n_wr[c]++;
            if (rq_addr[c].size() != 0) wr_out_viol++;
          end else begin
            rq_addr[c].push_back(ch_addr_o[c]);
            rq_cyc[c].push_back(cyc);
            n_rd[c]++;
          end
        end
        if (data_v_o[c] && data_yumi_i[c]) mem[c][wr_addr[c]] = data_o[c];
      end
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step(); step();
    reset_i = 1'b0;
    for (int c = 0; c < NC; c++) begin n_rd[c] = 0; n_wr[c] = 0; end
  endtask

  task automatic run_until_done(input logic [NC-1:0] mask, input int budget, output bit ok);
    int n = 0;
    while ((done_o & mask) != mask && n < budget) begin step(); n++; end
    ok = ((done_o & mask) == mask);
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0][0] = ent(OP_SEND, 1'b1, 8'h01, 8'h99);
    yumi_en = 0; rand_mode = 0; ret_budget = -1;
    reset_i = 1'b1;
    force_dv = 2'b11; force_data = 8'h3C;
    step(); step();
    checks++; if (v_o !== '0) begin failures++; $display("FAIL reset_v: got %b required 00", v_o); end
    checks++; if (data_v_o !== '0) begin failures++; $display("FAIL reset_data_v: got %b required 00", data_v_o); end
    checks++; if (done_o !== '0) begin failures++; $display("FAIL reset_done: got %b required 00", done_o); end
    checks++; if (error_o !== '0) begin failures++; $display("FAIL reset_error: got %b required 00", error_o); end
    checks++; if (all_done_o !== 1'b0) begin failures++; $display("FAIL reset_all_done: got %b required 0", all_done_o); end
    checks++; if (rom_addr_o !== '0) begin failures++; $display("FAIL reset_rom_addr: got %h required 0", rom_addr_o); end
    force_dv = '0;
    reset_i = 1'b0;
    step();
    checks++; if (error_o !== '0) begin failures++; $display("FAIL reset_ignores_data_v: error %b required 00", error_o); end
    checks++; if (v_o[0] !== 1'b1) begin failures++; $display("FAIL first_entry_valid: v_o[0] %b required 1", v_o[0]); end
    checks++; if (rom_addr_o[0] !== 4'd0) begin failures++; $display("FAIL stalled_pc: got %0d required 0", rom_addr_o[0]); end
    yumi_en = 1;
  endtask

  task automatic test_write_read();
    bit ok;
    clear_rom();
    rom[0][0] = ent(OP_SEND, 1'b1, 8'h40, 8'hA5);
    rom[0][1] = ent(OP_SEND, 1'b0, 8'h40, 8'hA5);
    do_reset();
    run_until_done(2'b11, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wr_rd_done: done %b required 11", done_o); end
    checks++; if (n_wr[0] !== 1 || n_rd[0] !== 1) begin failures++; $display("FAIL wr_rd_counts: wr %0d rd %0d required 1 1", n_wr[0], n_rd[0]); end
    checks++; if (mem[0][8'h40] !== 8'hA5) begin failures++; $display("FAIL wr_rd_mem: got %h required a5", mem[0][8'h40]); end
    checks++; if (error_o[0] !== 1'b0) begin failures++; $display("FAIL wr_rd_error: got %b required 0", error_o[0]); end
    checks++; if (rom_addr_o[0] !== 4'd3) begin failures++; $display("FAIL wr_rd_pc: got %0d required 3", rom_addr_o[0]); end
    checks++; if (all_done_o !== 1'b1) begin failures++; $display("FAIL wr_rd_all_done: got %b required 1", all_done_o); end
  endtask

  task automatic test_outstanding();
    bit ok;
    clear_rom();
    for (int i = 0; i < 4; i++) rom[0][i] = ent(OP_SEND, 1'b0, AW'(i + 1), DW'(i + 1));
    ret_budget = 0;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    checks++; if (n_rd[0] !== 2) begin failures++; $display("FAIL limit_accepted: got %0d required 2", n_rd[0]); end
    checks++; if (v_o[0] !== 1'b0) begin failures++; $display("FAIL limit_v_low: got %b required 0", v_o[0]); end
    ret_budget = 1;
    step();
    checks++; if (n_rd[0] !== 2) begin failures++; $display("FAIL limit_same_cycle: got %0d required 2", n_rd[0]); end
    step();
    checks++; if (v_o[0] !== 1'b1 || n_rd[0] !== 3) begin failures++; $display("FAIL limit_third: v %b rd %0d required 1 3", v_o[0], n_rd[0]); end
    ret_budget = -1;
    run_until_done(2'b01, 60, ok);
    checks++; if (!ok || n_rd[0] !== 4 || error_o[0] !== 1'b0) begin failures++; $display("FAIL limit_finish: done %b rd %0d err %b required 1 4 0", done_o[0], n_rd[0], error_o[0]); end
  endtask

  task automatic test_mismatch();
    bit ok;
    clear_rom();
    mem[0][8'h20] = 8'h12;
    rom[0][0] = ent(OP_SEND, 1'b0, 8'h20, 8'h11);
    rom[0][1] = ent(OP_SEND, 1'b0, 8'h21, 8'h21);
    do_reset();
    run_until_done(2'b01, 60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mismatch_done: got %b required 1", done_o[0]); end
    checks++; if (error_o[0] !== 1'b1) begin failures++; $display("FAIL mismatch_error: got %b required 1", error_o[0]); end
    checks++; if (n_rd[0] !== 2) begin failures++; $display("FAIL mismatch_continues: rd %0d required 2", n_rd[0]); end
    step(); step();
    checks++; if (error_o !== 2'b01) begin failures++; $display("FAIL mismatch_sticky: got %b required 01", error_o); end
    mem[0][8'h20] = 8'h20;
  endtask

  task automatic test_underflow();
    bit ok;
    clear_rom();
    do_reset();
    force_dv = 2'b01; force_data = 8'h00;
    step();
    force_dv = '0;
    run_until_done(2'b01, 10, ok);
    checks++; if (error_o !== 2'b01) begin failures++; $display("FAIL underflow_error: got %b required 01", error_o); end
    checks++; if (!ok) begin failures++; $display("FAIL underflow_count_zero: done %b required 1", done_o[0]); end
    checks++; if (n_rd[0] !== 0) begin failures++; $display("FAIL underflow_reads: got %0d required 0", n_rd[0]); end
  endtask

  task automatic test_illegal_op();
    clear_rom();
    rom[0][0] = ent(4'h7, 1'b0, 8'h00, 8'h00);
    do_reset();
    step(); step(); step();
    checks++; if (error_o[0] !== 1'b1 || done_o[0] !== 1'b1) begin failures++; $display("FAIL illegal_op: err %b done %b required 1 1", error_o[0], done_o[0]); end
    checks++; if (rom_addr_o[0] !== 4'd0) begin failures++; $display("FAIL illegal_op_pc: got %0d required 0", rom_addr_o[0]); end
  endtask

  task automatic test_drain_op();
    bit ok;
    clear_rom();
    rom[0][0] = ent(OP_SEND, 1'b0, 8'h05, 8'h05);
    rom[0][1] = ent(OP_DRAIN, 1'b0, 8'h00, 8'h00);
    rom[0][2] = ent(OP_SEND, 1'b1, 8'h06, 8'h77);
    wr_out_viol = 0;
    do_reset();
    run_until_done(2'b01, 40, ok);
    checks++; if (!ok || error_o[0] !== 1'b0) begin failures++; $display("FAIL drain_done: done %b err %b required 1 0", done_o[0], error_o[0]); end
    checks++; if (wr_out_viol !== 0) begin failures++; $display("FAIL drain_order: writes during reads %0d required 0", wr_out_viol); end
    checks++; if (mem[0][8'h06] !== 8'h77 || rom_addr_o[0] !== 4'd4) begin failures++; $display("FAIL drain_write: mem %h pc %0d required 77 4", mem[0][8'h06], rom_addr_o[0]); end
  endtask

  task automatic test_pc_wrap();
    int n = 0;
    clear_rom();
    for (int i = 0; i < 16; i++) rom[0][i] = ent(OP_DRAIN, 1'b0, 8'h00, 8'h00);
    do_reset();
    step();
    while (rom_addr_o[0] !== 4'd15 && n < 60) begin step(); n++; end
    checks++; if (rom_addr_o[0] !== 4'd15) begin failures++; $display("FAIL wrap_reach: pc %0d required 15", rom_addr_o[0]); end
    step(); step();
    checks++; if (rom_addr_o[0] !== 4'd0 || error_o[0] !== 1'b0) begin failures++; $display("FAIL wrap: pc %0d err %b required 0 0", rom_addr_o[0], error_o[0]); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_rom();
    for (int c = 0; c < NC; c++) begin
      logic [7:0] b;
      b = 8'h10 + 8'(c * 8'h20);
      rom[c][0] = ent(OP_SEND, 1'b1, b, 8'h5A + 8'(c));
      rom[c][1] = ent(OP_SEND, 1'b0, b, 8'h5A + 8'(c));
      rom[c][2] = ent(OP_SEND, 1'b1, b + 8'h1, 8'h3C + 8'(c));
      rom[c][3] = ent(OP_SEND, 1'b0, b + 8'h1, 8'h3C + 8'(c));
      rom[c][4] = ent(OP_SEND, 1'b0, b, 8'h5A + 8'(c));
      rom[c][5] = ent(OP_DRAIN, 1'b0, 8'h00, 8'h00);
      rom[c][6] = ent(OP_SEND, 1'b0, b + 8'h1, 8'h3C + 8'(c));
    end
    rand_mode = 1; yumi_en = 1; ret_budget = -1;
    do_reset();
    for (int i = 0; i < 12; i++) step();
    reset_i = 1'b1;
    step();
    checks++; if (v_o !== '0 || data_v_o !== '0 || done_o !== '0 || error_o !== '0 || all_done_o !== 1'b0)
      begin failures++; $display("FAIL midreset_outputs: v %b dv %b done %b err %b required all 0", v_o, data_v_o, done_o, error_o); end
    checks++; if (rom_addr_o !== '0) begin failures++; $display("FAIL midreset_rom_addr: got %h required 0", rom_addr_o); end
    step();
    reset_i = 1'b0;
    for (int c = 0; c < NC; c++) begin n_rd[c] = 0; n_wr[c] = 0; end
    step();
    checks++; if (rom_addr_o !== '0) begin failures++; $display("FAIL restart_pc: got %h required 0", rom_addr_o); end
    run_until_done(2'b11, 800, ok);
    checks++; if (!ok || all_done_o !== 1'b1) begin failures++; $display("FAIL stress_all_done: got %b required 1", all_done_o); end
    checks++; if (error_o !== '0) begin failures++; $display("FAIL stress_error: got %b required 00", error_o); end
    checks++; if (n_rd[0] !== 4 || n_wr[1] !== 2) begin failures++; $display("FAIL stress_counts: rd0 %0d wr1 %0d required 4 2", n_rd[0], n_wr[1]); end
    checks++; if (mem[1][8'h31] !== 8'h3D) begin failures++; $display("FAIL stress_mem: got %h required 3d", mem[1][8'h31]); end
    rand_mode = 0;
  endtask

  initial begin
    reset_i = 1'b1;
    yumi_i = '0; data_yumi_i = '0; data_v_i = '0; data_i = '0;
    for (int c = 0; c < NC; c++) begin
      n_rd[c] = 0; n_wr[c] = 0; wr_addr[c] = '0;
      for (int a = 0; a < 256; a++) mem[c][a] = 8'(a);
    end
    clear_rom();
    test_reset();
    test_write_read();
    test_outstanding();
    test_mismatch();
    test_underflow();
    test_illegal_op();
    test_drain_op();
    test_pc_wrap();
    test_back_to_back();
    checks++; if (both_hi !== 0) begin failures++; $display("FAIL v_and_data_v_together: got %0d required 0", both_hi); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_nonsynth_dram_trace_player.md
BSG_NONSYNTH_DRAM_TRACE_PLAYER -- requirements
Module: bsg_nonsynth_dram_trace_player

Interface
REQ-001 SHALL have parameter num_channels_p, default 8: number of independent DRAM channels driven.
REQ-002 SHALL have parameter channel_addr_width_p, default 29: per-channel address width.
REQ-003 SHALL have parameter data_width_p, default 256: per-channel data width.
REQ-004 SHALL have parameter rom_addr_width_p, default 20: trace ROM address width.
REQ-005 SHALL have parameter max_outstanding_p, default 8: per-channel read-in-flight limit; must be at least 1.
REQ-006 SHALL define entry width ew = 4+1+channel_addr_width_p+data_width_p, packed MSB to LSB as {op[3:0], write_not_read, ch_addr, data}.
REQ-007 SHALL have port clk_i, input, 1: the single clock.
REQ-008 SHALL have port reset_i, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port rom_addr_o, output, num_channels_p x rom_addr_width_p: per-channel trace pointer.
REQ-010 SHALL have port rom_data_i, input, num_channels_p x ew: combinational ROM entry at rom_addr_o.
REQ-011 SHALL have port v_o, output, num_channels_p: request valid.
REQ-012 SHALL have port write_not_read_o, output, num_channels_p: request type.
REQ-013 SHALL have port ch_addr_o, output, num_channels_p x channel_addr_width_p: request address.
REQ-014 SHALL have port yumi_i, input, num_channels_p: request accepted.
REQ-015 SHALL have port data_v_o, output, num_channels_p: write data valid.
REQ-016 SHALL have port data_o, output, num_channels_p x data_width_p: write data.
REQ-017 SHALL have port data_yumi_i, input, num_channels_p: write data accepted.
REQ-018 SHALL have port data_v_i, input, num_channels_p: read data return valid; always accepted.
REQ-019 SHALL have port data_i, input, num_channels_p x data_width_p: read data return.
REQ-020 SHALL have port done_o, output, num_channels_p: channel reached DONE.
REQ-021 SHALL have port error_o, output, num_channels_p: sticky channel error.
REQ-022 SHALL have port all_done_o, output, 1: AND of done_o.

Function
REQ-023 SHALL run an identical, independent FSM per channel, with states SEND, WDATA, DRAIN and DONE.
REQ-024 SHALL define ops as 0=SEND, 1=DRAIN, 2=FINISH; any other op SHALL set error and go to DONE.
REQ-025 SHALL drive rom_addr_o from the channel pc; each entry is consumed by incrementing pc by 1.
REQ-026 SEND with op=SEND SHALL assert v_o, driving write_not_read_o and ch_addr_o from the entry.
REQ-027 For a read, v_o SHALL be held low while outstanding==max_outstanding_p.
REQ-028 Read accepted (v_o and yumi_i) SHALL push the entry data field into the channel's expected-data FIFO (depth max_outstanding_p), increment pc, and stay in SEND.
REQ-029 Write accepted SHALL latch the entry data and go to WDATA; pc is unchanged until the data is accepted.
REQ-030 WDATA SHALL assert data_v_o with the latched data; on data_yumi_i it SHALL increment pc and return to SEND.
REQ-031 v_o and data_v_o SHALL never be high in the same cycle on one channel.
REQ-032 op=DRAIN SHALL go to DRAIN; DRAIN SHALL exit with pc+1 back to SEND in the first cycle outstanding==0, which may be the same cycle as the final return.
REQ-033 op=FINISH SHALL go to DRAIN-then-DONE: done_o SHALL rise in the cycle after outstanding reaches 0; DONE is terminal until reset.
REQ-034 On data_v_i, data_i SHALL be compared with the FIFO head, the head popped, and outstanding decremented; a mismatch SHALL set error_o.
REQ-035 data_v_i with an empty FIFO SHALL set error_o, leaving the count at 0 with no underflow.
REQ-036 A push and a pop in the same cycle SHALL leave outstanding unchanged; the FIFO SHALL pass through correctly when only the pushed entry is present.
REQ-037 error_o SHALL NOT stop replay except for an illegal op.
REQ-038 pc SHALL wrap modulo 2^rom_addr_width_p without flagging an error.

Reset
REQ-039 While reset_i is high at a clock edge, every channel SHALL enter SEND with pc=0, FIFO empty, outstanding=0 and error cleared.
REQ-040 During reset, v_o, data_v_o, done_o, error_o and all_done_o SHALL be 0, and rom_addr_o SHALL be 0.
REQ-041 Reset asserted mid-transaction SHALL abandon all in-flight state; data_v_i during reset SHALL be ignored.

Verification
REQ-042 Ch0 trace {SEND wr 0x40 data=0xA5, SEND rd 0x40 exp=0xA5, FINISH}, with the memory echoing writes -> one write then one read issued, done_o[0]=1, error_o[0]=0.
REQ-043 max_outstanding_p=2, 4 reads, yumi_i=1, returns withheld -> exactly 2 accepted, v_o low until the first return, then the 3rd is issued.
REQ-044 Read expecting 0x11 but returned 0x12 -> error_o sticky 1 and replay continues to done_o=1.
REQ-045 data_v_i pulse with no reads issued -> error_o=1 and outstanding stays 0.
REQ-046 All channels, random yumi_i/data_yumi_i stalls, plus a reset pulse mid-trace -> outputs zero during reset; replay restarts at pc=0 and all_done_o=1 with no errors.
